// File: rtl/pw_meter.sv
// -----------------------------------------------------------------------------
// pw_meter -- pulse-train meter.
//
// Samples a pulse line on ce ticks and recovers the period (rising edge to
// rising edge) and high width (rising edge to falling edge) of each complete
// cycle. Both are counted in ce ticks. Each complete period is reported with
// a one-clk `valid` strobe. If the counter saturates during a period, that
// measurement is dropped and `err` strobes instead.
//
// Parameters:
//   W       counter and result width (default 11)
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   ce      in   tick enable; sampling and counting advance only when high
//   PW      in   pulse line being measured
//   period  out  [W]  last reported period in ce ticks
//   width   out  [W]  last reported high width, same period as `period`
//   valid   out  one-clk strobe: period/width updated this cycle
//   err     out  one-clk strobe: measurement discarded on counter saturation
//
// Build option:
//   PW_METER_SYNC_EN  when defined, PW passes through a 2-flop synchronizer
//                     clocked every clk before ce sampling. This is safe for
//                     asynchronous sources and adds 2 clk of latency.
// -----------------------------------------------------------------------------
module pw_meter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         PW,
  output logic [W-1:0] period,
  output logic [W-1:0] width,
  output logic         valid,
  output logic         err
);

  typedef enum logic [1:0] {
    SYNC = 2'd0,  // waiting for the first rise; nothing to report yet
    HIGH = 2'd1,  // inside the high phase, waiting for the fall
    LOW  = 2'd2   // inside the low phase, waiting for the rise that closes the period
  } state_t;

  state_t         state_q, state_d;
  logic           pw_in;
  logic           pw_s;
  logic [W-1:0]   cnt;
  logic [W-1:0]   width_pend;
  logic           bad;
  logic           rise, fall, sat;
  logic           capture_w, report, discard;

`ifdef PW_METER_SYNC_EN
  logic [1:0] sync_q;

  // Metastability guard for asynchronous sources. It runs every clk, not only
  // on ce, so its latency stays a fixed 2 clk regardless of the ce rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], PW};
  end

  assign pw_in = sync_q[1];
`else
  assign pw_in = PW;
`endif

  // Edges are detected against the previous ce sample, not the previous clk.
  assign rise = ce &  pw_in & ~pw_s;
  assign fall = ce & ~pw_in &  pw_s;
  assign sat  = &cnt;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    capture_w = 1'b0;
    report    = 1'b0;
    discard   = 1'b0;
    unique case (state_q)
      SYNC: if (rise) state_d = HIGH;
      HIGH: if (fall) begin
        state_d   = LOW;
        capture_w = 1'b1;
      end
      LOW:  if (rise) begin
        state_d = HIGH;
        if (bad || sat) discard = 1'b1;
        else            report  = 1'b1;
      end
      default: state_d = SYNC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SYNC;
    else        state_q <= state_d;
  end

  // NOTE: all of these registers are reset. The counter and the pending width
  // are small flops, not memory, and a reset mid-period must discard partial
  // measurements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pw_s       <= 1'b0;
      cnt        <= '0;
      width_pend <= '0;
      bad        <= 1'b0;
    end else begin
      if (ce) begin
        pw_s <= pw_in;
        // The rise tick itself is the first high tick of the new period, so
        // the count restarts at 1. It then holds at all-ones until the next rise.
        if (rise)     cnt <= W'(1);
        else if (!sat) cnt <= cnt + W'(1);
      end
      if (capture_w) width_pend <= cnt;
      // The bad flag remembers that the high phase overflowed. It is acted on
      // only when the closing rise arrives.
      if (rise)                  bad <= 1'b0;
      else if (capture_w && sat) bad <= 1'b1;
    end
  end

  // Period and width load together from one decision, so they always
  // describe the same period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period <= '0;
      width  <= '0;
      valid  <= 1'b0;
      err    <= 1'b0;
    end else begin
      valid <= report;
      err   <= discard;
      if (report) begin
        period <= cnt;
        width  <= width_pend;
      end
    end
  end

endmodule

// File: tb/tb_pw_meter.sv
// -----------------------------------------------------------------------------
// tb_pw_meter -- directed self-checking bench for pw_meter.
//
// Two instances share clk/rst_n/ce: the default W=11 meter and a W=4 meter
// used to reach counter saturation quickly. A negedge monitor counts strobes
// and captures the values seen with each valid. Each scenario task drives a
// pulse train and compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_pw_meter;

  localparam int W = 11;
`ifdef PW_METER_SYNC_EN
  localparam int LAT = 3;  // drive -> valid visible, in clk
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ce = 1'b0;
  logic         pw = 1'b0;
  logic         pw4 = 1'b0;
  logic [W-1:0] period, width;
  logic         valid, err;
  logic [3:0]   period4, width4;
  logic         valid4, err4;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rise_cyc = 0;

  // Monitor state.
  int vcount = 0, ecount = 0, v4count = 0, e4count = 0;
  int last_vcyc = 0, prev_vcyc = 0, run = 0, max_run = 0;
  logic [W-1:0] vp = '0, vw = '0;
  logic [3:0]   vp4 = '0, vw4 = '0;

  pw_meter #(.W(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .PW(pw),
    .period(period), .width(width), .valid(valid), .err(err)
  );

  pw_meter #(.W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .PW(pw4),
    .period(period4), .width(width4), .valid(valid4), .err(err4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vcount++;
      prev_vcyc = last_vcyc;
      last_vcyc = cyc;
      vp = period;
      vw = width;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (err) ecount++;
    if (valid4) begin
      v4count++;
      vp4 = period4;
      vw4 = width4;
    end
    if (err4) e4count++;
  end

  // One ce tick: set the line, then run `div` clks with ce high on the last.
  task automatic ce_tick(input int div, input logic val, input bit sel4);
    if (sel4) pw4 = val;
    else      pw  = val;
    for (int j = 0; j < div; j++) begin
      ce = (j == div - 1);
      @(posedge clk); #1;
    end
  endtask

  // One generator period: n ticks, the first mt of them high.
  task automatic send_period(input int div, input int n, input int mt, input bit sel4);
    rise_cyc = cyc;
    for (int i = 0; i < n; i++) ce_tick(div, (i < mt), sel4);
  endtask

  task automatic test_reset();
    ce = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pw = (i % 2 == 0);
      @(posedge clk); #1;
    end
    checks++; if (period !== '0) begin $display("FAIL reset_period got=%0d exp=0", period); failures++; end
    checks++; if (width !== '0)  begin $display("FAIL reset_width got=%0d exp=0", width); failures++; end
    checks++; if (valid !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", valid); failures++; end
    checks++; if (err !== 1'b0)   begin $display("FAIL reset_err got=%b exp=0", err); failures++; end
    checks++; if (vcount !== 0)   begin $display("FAIL reset_vcount got=%0d exp=0", vcount); failures++; end
    pw = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_period(1, 10, 3, 0);
    checks++; if (vcount !== 0) begin $display("FAIL sync_no_valid got=%0d exp=0", vcount); failures++; end
    checks++; if (ecount !== 0) begin $display("FAIL sync_no_err got=%0d exp=0", ecount); failures++; end
  endtask

  task automatic test_loopback();
    int v0;
    v0 = vcount;
    for (int k = 0; k < 3; k++) send_period(1, 10, 3, 0);
    checks++; if (vcount - v0 !== 3) begin $display("FAIL loop10_count got=%0d exp=3", vcount - v0); failures++; end
    checks++; if (vp !== 11'd10) begin $display("FAIL loop10_period got=%0d exp=10", vp); failures++; end
    checks++; if (vw !== 11'd3)  begin $display("FAIL loop10_width got=%0d exp=3", vw); failures++; end
    checks++; if (last_vcyc - prev_vcyc !== 10) begin $display("FAIL loop10_spacing got=%0d exp=10", last_vcyc - prev_vcyc); failures++; end
    checks++; if (last_vcyc - rise_cyc !== LAT) begin $display("FAIL loop10_latency got=%0d exp=%0d", last_vcyc - rise_cyc, LAT); failures++; end
    v0 = vcount;
    for (int k = 0; k < 2; k++) send_period(1, 7, 5, 0);
    checks++; if (vcount - v0 !== 2) begin $display("FAIL loop7_count got=%0d exp=2", vcount - v0); failures++; end
    checks++; if (vp !== 11'd7) begin $display("FAIL loop7_period got=%0d exp=7", vp); failures++; end
    checks++; if (vw !== 11'd5) begin $display("FAIL loop7_width got=%0d exp=5", vw); failures++; end
    checks++; if (last_vcyc - prev_vcyc !== 7) begin $display("FAIL loop7_spacing got=%0d exp=7", last_vcyc - prev_vcyc); failures++; end
  endtask

  task automatic test_ce_div();
    int v0;
    v0 = vcount;
    for (int k = 0; k < 3; k++) send_period(4, 5, 2, 0);
    checks++; if (vcount - v0 !== 3) begin $display("FAIL cediv_count got=%0d exp=3", vcount - v0); failures++; end
    checks++; if (vp !== 11'd5) begin $display("FAIL cediv_period got=%0d exp=5", vp); failures++; end
    checks++; if (vw !== 11'd2) begin $display("FAIL cediv_width got=%0d exp=2", vw); failures++; end
    checks++; if (last_vcyc - prev_vcyc !== 20) begin $display("FAIL cediv_spacing got=%0d exp=20", last_vcyc - prev_vcyc); failures++; end
    checks++; if (max_run !== 1) begin $display("FAIL cediv_strobe_len got=%0d exp=1", max_run); failures++; end
  endtask

  task automatic test_saturation();
    ce = 1'b1;
    send_period(1, 6, 2, 1);   // rise is the sync edge
    send_period(1, 23, 3, 1);  // its rise reports 6/2
    checks++; if (v4count !== 1) begin $display("FAIL sat_first_valid got=%0d exp=1", v4count); failures++; end
    checks++; if (vp4 !== 4'd6)  begin $display("FAIL sat_first_period got=%0d exp=6", vp4); failures++; end
    checks++; if (vw4 !== 4'd2)  begin $display("FAIL sat_first_width got=%0d exp=2", vw4); failures++; end
    checks++; if (e4count !== 0) begin $display("FAIL sat_no_err_yet got=%0d exp=0", e4count); failures++; end
    send_period(1, 8, 3, 1);   // its rise closes the 23-tick period: err
    checks++; if (e4count !== 1) begin $display("FAIL sat_err got=%0d exp=1", e4count); failures++; end
    checks++; if (v4count !== 1) begin $display("FAIL sat_no_valid got=%0d exp=1", v4count); failures++; end
    checks++; if (period4 !== 4'd6) begin $display("FAIL sat_hold_period got=%0d exp=6", period4); failures++; end
    checks++; if (width4 !== 4'd2)  begin $display("FAIL sat_hold_width got=%0d exp=2", width4); failures++; end
    ce_tick(1, 1'b1, 1);
    for (int k = 0; k < 5; k++) ce_tick(1, 1'b0, 1);
    checks++; if (v4count !== 2) begin $display("FAIL sat_recover_valid got=%0d exp=2", v4count); failures++; end
    checks++; if (vp4 !== 4'd8)  begin $display("FAIL sat_recover_period got=%0d exp=8", vp4); failures++; end
    checks++; if (vw4 !== 4'd3)  begin $display("FAIL sat_recover_width got=%0d exp=3", vw4); failures++; end
    checks++; if (e4count !== 1) begin $display("FAIL sat_recover_err got=%0d exp=1", e4count); failures++; end
  endtask

  task automatic test_reset_mid();
    int v0, e0;
    for (int k = 0; k < 3; k++) ce_tick(1, 1'b1, 0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (period !== '0) begin $display("FAIL midrst_period got=%0d exp=0", period); failures++; end
    checks++; if (width !== '0)  begin $display("FAIL midrst_width got=%0d exp=0", width); failures++; end
    checks++; if (valid !== 1'b0) begin $display("FAIL midrst_valid got=%b exp=0", valid); failures++; end
    checks++; if (err !== 1'b0)   begin $display("FAIL midrst_err got=%b exp=0", err); failures++; end
    pw = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    v0 = vcount;
    e0 = ecount;
    send_period(1, 10, 3, 0);
    checks++; if (vcount - v0 !== 0) begin $display("FAIL midrst_sync_valid got=%0d exp=0", vcount - v0); failures++; end
    checks++; if (ecount - e0 !== 0) begin $display("FAIL midrst_sync_err got=%0d exp=0", ecount - e0); failures++; end
    send_period(1, 6, 2, 0);
    checks++; if (vcount - v0 !== 1) begin $display("FAIL midrst_valid_count got=%0d exp=1", vcount - v0); failures++; end
    checks++; if (vp !== 11'd10) begin $display("FAIL midrst_period_after got=%0d exp=10", vp); failures++; end
    checks++; if (vw !== 11'd3)  begin $display("FAIL midrst_width_after got=%0d exp=3", vw); failures++; end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = vcount;
    send_period(1, 4, 1, 0);  // rise reports 6/2
    send_period(1, 2, 1, 0);  // rise reports 4/1
    send_period(1, 2, 1, 0);  // rise reports 2/1
    ce_tick(1, 1'b1, 0);      // rise reports 2/1
    for (int k = 0; k < 5; k++) ce_tick(1, 1'b0, 0);
    checks++; if (vcount - v0 !== 4) begin $display("FAIL b2b_count got=%0d exp=4", vcount - v0); failures++; end
    checks++; if (vp !== 11'd2) begin $display("FAIL b2b_period got=%0d exp=2", vp); failures++; end
    checks++; if (vw !== 11'd1) begin $display("FAIL b2b_width got=%0d exp=1", vw); failures++; end
    checks++; if (last_vcyc - prev_vcyc !== 2) begin $display("FAIL b2b_spacing got=%0d exp=2", last_vcyc - prev_vcyc); failures++; end
    checks++; if (max_run !== 1) begin $display("FAIL b2b_strobe_len got=%0d exp=1", max_run); failures++; end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_ce_div();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
